// File: rtl/softmax_seq_pkg.sv
// Shared definitions for the sequential softmax attention block.
//   state_t  : controller states
//   idx_w    : width of a token index for N tokens
//   sum_w    : width of the exp accumulator for N tokens
//   exp_neg  : 8-bit exp(-d) approximation, 255 >> d[7:5]
package softmax_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DOT,
    S_EXP,
    S_DIV,
    S_OUT
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned sum_w(input int unsigned n);
    return 8 + $clog2(n) + 1;
  endfunction

  function automatic logic [7:0] exp_neg(input logic [7:0] d);
    return 8'd255 >> d[7:5];
  endfunction

endpackage

// File: rtl/softmax_attention_seq_if.sv
// Transaction interface of softmax_attention_seq.
//   Request  : valid_in/ready_in, q_sel, q_bus, k_bus (token i at [i*WIDTH +: WIDTH])
//   Response : valid_out/ready_out, winner, score_bus (token i at [i*SCORE_W +: SCORE_W])
//   Status   : busy
//   slave modport is the block, master modport is the requester.
interface softmax_attention_seq_if #(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SCORE_W = 8
) ();

  localparam int unsigned IDX_W = softmax_seq_pkg::idx_w(N);

  logic                   valid_in;
  logic                   ready_in;
  logic [IDX_W-1:0]       q_sel;
  logic [N*WIDTH-1:0]     q_bus;
  logic [N*WIDTH-1:0]     k_bus;
  logic                   valid_out;
  logic                   ready_out;
  logic [IDX_W-1:0]       winner;
  logic [N*SCORE_W-1:0]   score_bus;
  logic                   busy;

  modport slave (
    input  valid_in, q_sel, q_bus, k_bus, ready_out,
    output ready_in, valid_out, winner, score_bus, busy
  );

  modport master (
    output valid_in, q_sel, q_bus, k_bus, ready_out,
    input  ready_in, valid_out, winner, score_bus, busy
  );

endinterface

// File: rtl/seq_divider_restoring.sv
// Serial restoring divider producing a Q_W-bit quotient in Q_W cycles.
//   start : load num/den (one cycle), iterations follow on the next Q_W edges
//   num   : dividend, must satisfy num < den * 2^Q_W
//   den   : divisor, non-zero
//   done  : high during the cycle whose edge completes the last iteration
//   quo   : quotient, valid while done is high
module seq_divider_restoring #(
  parameter int unsigned NUM_W = 16,
  parameter int unsigned DEN_W = 11,
  parameter int unsigned Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [Q_W-1:0]   quo
);

  localparam int unsigned CNT_W = $clog2(Q_W + 1);

  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den_r;
  logic [Q_W-1:0]   q_sh;
  logic [CNT_W-1:0] cnt;
  logic             running;

  logic [DEN_W:0]   trial;
  logic             fits;
  logic [DEN_W-1:0] rem_next;
  logic [Q_W-1:0]   q_next;

  // Because the quotient fits Q_W bits, num >> Q_W is already below den and
  // can seed the remainder; only the low Q_W dividend bits need iterating.
  // q_sh shifts dividend bits out of its MSB and quotient bits into its LSB.
  always_comb begin
    trial    = {rem, q_sh[Q_W-1]};
    fits     = (trial >= {1'b0, den_r});
    rem_next = fits ? DEN_W'(trial - {1'b0, den_r}) : trial[DEN_W-1:0];
    q_next   = (q_sh << 1) | Q_W'(fits);
  end

  assign done = running && (cnt == CNT_W'(1));
  assign quo  = q_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      den_r   <= '0;
      q_sh    <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= DEN_W'(num >> Q_W);
      den_r   <= den;
      q_sh    <= num[Q_W-1:0];
      cnt     <= CNT_W'(Q_W);
      running <= 1'b1;
    end else if (running) begin
      rem     <= rem_next;
      q_sh    <= q_next;
      cnt     <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_attention_seq.sv
// Resource-shared softmax attention over N tokens.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of softmax_attention_seq_if (request, response, busy)
// One query element (q_bus[q_sel]) is multiplied with each key on a single
// multiplier (DOT), max-subtracted exp approximations are summed (EXP), and
// each score e_i*(2^SCORE_W-1)/sum is produced by a serial divider (DIV).
// Result and argmax winner are held in OUT until accepted.
module softmax_attention_seq
  import softmax_seq_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned SHIFT   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  softmax_attention_seq_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(N);
  localparam int unsigned SUM_W = sum_w(N);
  localparam int unsigned DOT_W = 2 * WIDTH;
  localparam int unsigned NUM_W = 8 + SCORE_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t state, state_next;

  logic [WIDTH-1:0]   q_arr [N];
  logic [WIDTH-1:0]   qv;
  logic [WIDTH-1:0]   k_r [N];
  logic [DOT_W-1:0]   dot_r [N];
  logic [DOT_W-1:0]   max_dot;
  logic [IDX_W-1:0]   winner_r;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         e_r [N];
  logic [SUM_W-1:0]   sum_r;
  logic               launch;
  logic [SCORE_W-1:0] score_r [N];

  logic               accept;
  logic               last_idx;
  logic               ready_in_c, busy_c, valid_out_c;
  logic [DOT_W-1:0]   prod;
  logic [DOT_W-1:0]   diff;
  logic [7:0]         d_sat;
  logic [7:0]         e_cur;
  logic               div_start;
  logic               div_done;
  logic [NUM_W-1:0]   div_num;
  logic [SCORE_W-1:0] div_quo;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) q_arr[i] = bus.q_bus[i*WIDTH +: WIDTH];
  end

  assign last_idx = (idx == LAST);
  assign prod     = DOT_W'(qv) * DOT_W'(k_r[idx]);
  assign diff     = (max_dot - dot_r[idx]) >> SHIFT;
  assign d_sat    = (diff > DOT_W'(255)) ? 8'd255 : diff[7:0];
  assign e_cur    = exp_neg(d_sat);
  assign div_num  = (NUM_W'(e_r[idx]) << SCORE_W) - NUM_W'(e_r[idx]);

  seq_divider_restoring #(
    .NUM_W (NUM_W),
    .DEN_W (SUM_W),
    .Q_W   (SCORE_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (sum_r),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // DIV alternates a launch cycle with SCORE_W iteration cycles; the divider's
  // done/quo are combinational so the score is captured on the edge that
  // completes the last iteration, keeping each token at SCORE_W+1 cycles.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    div_start   = 1'b0;
    ready_in_c  = 1'b0;
    busy_c      = 1'b1;
    valid_out_c = 1'b0;
    case (state)
      S_IDLE: begin
        ready_in_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.valid_in) begin
          accept     = 1'b1;
          state_next = S_DOT;
        end
      end
      S_DOT: if (last_idx) state_next = S_EXP;
      S_EXP: if (last_idx) state_next = S_DIV;
      S_DIV: begin
        div_start = launch;
        if (!launch && div_done && last_idx) state_next = S_OUT;
      end
      S_OUT: begin
        valid_out_c = 1'b1;
        if (bus.ready_out) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qv       <= '0;
      max_dot  <= '0;
      winner_r <= '0;
      idx      <= '0;
      sum_r    <= '0;
      launch   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        k_r[i]     <= '0;
        dot_r[i]   <= '0;
        e_r[i]     <= '0;
        score_r[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          qv       <= q_arr[bus.q_sel];
          for (int unsigned i = 0; i < N; i++) k_r[i] <= bus.k_bus[i*WIDTH +: WIDTH];
          idx      <= '0;
          max_dot  <= '0;
          winner_r <= '0;
          sum_r    <= '0;
        end
        S_DOT: begin
          dot_r[idx] <= prod;
          // strict compare keeps the lowest index on ties
          if (idx == '0 || prod > max_dot) begin
            max_dot  <= prod;
            winner_r <= idx;
          end
          idx <= last_idx ? '0 : idx + 1'b1;
        end
        S_EXP: begin
          e_r[idx] <= e_cur;
          sum_r    <= sum_r + SUM_W'(e_cur);
          idx      <= last_idx ? '0 : idx + 1'b1;
          if (last_idx) launch <= 1'b1;
        end
        S_DIV: begin
          if (launch) begin
            launch <= 1'b0;
          end else if (div_done) begin
            score_r[idx] <= div_quo;
            if (!last_idx) begin
              idx    <= idx + 1'b1;
              launch <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.score_bus = '0;
    for (int unsigned i = 0; i < N; i++) bus.score_bus[i*SCORE_W +: SCORE_W] = score_r[i];
  end

  assign bus.ready_in  = ready_in_c;
  assign bus.busy      = busy_c;
  assign bus.valid_out = valid_out_c;
  assign bus.winner    = winner_r;

endmodule

// File: tb/tb_softmax_attention_seq.sv
module tb_softmax_attention_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_attention_seq_if #(.N(4), .WIDTH(8),  .SCORE_W(8))  bus_a ();
  softmax_attention_seq_if #(.N(8), .WIDTH(12), .SCORE_W(10)) bus_b ();

  softmax_attention_seq #(.N(4), .WIDTH(8), .SCORE_W(8), .SHIFT(0)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  softmax_attention_seq #(.N(8), .WIDTH(12), .SCORE_W(10), .SHIFT(0)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: softmax by plain arithmetic on integers.
  function automatic void ref_model(input int n, input int s, input int shift,
                                    input int unsigned q, input int unsigned k[8],
                                    output int unsigned sc[8], output int unsigned win);
    longint unsigned dots[8];
    longint unsigned mx = 0;
    longint unsigned e[8];
    longint unsigned tot = 0;
    win = 0;
    for (int i = 0; i < 8; i++) sc[i] = 0;
    for (int i = 0; i < n; i++) begin
      dots[i] = longint'(q) * longint'(k[i]);
      if (dots[i] > mx) begin mx = dots[i]; win = i; end
    end
    for (int i = 0; i < n; i++) begin
      longint unsigned d = (mx - dots[i]) >> shift;
      if (d > 255) d = 255;
      e[i] = 255 >> (d / 32);
      tot += e[i];
    end
    for (int i = 0; i < n; i++) sc[i] = int'(e[i] * ((64'd1 << s) - 1) / tot);
  endfunction

  function automatic logic [63:0] get_score(input int inst, input int i);
    if (inst == 0) return 64'(bus_a.score_bus[i*8 +: 8]);
    return 64'(bus_b.score_bus[i*10 +: 10]);
  endfunction

  function automatic logic [63:0] get_winner(input int inst);
    return (inst == 0) ? 64'(bus_a.winner) : 64'(bus_b.winner);
  endfunction

  function automatic logic get_valid_out(input int inst);
    return (inst == 0) ? bus_a.valid_out : bus_b.valid_out;
  endfunction

  function automatic logic get_ready_in(input int inst);
    return (inst == 0) ? bus_a.ready_in : bus_b.ready_in;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? bus_a.busy : bus_b.busy;
  endfunction

  task automatic scramble(input int inst);
    if (inst == 0) begin
      bus_a.q_bus = 32'($urandom); bus_a.k_bus = 32'($urandom); bus_a.q_sel = 2'($urandom);
    end else begin
      bus_b.q_bus = {32'($urandom), 32'($urandom), 32'($urandom)};
      bus_b.k_bus = {32'($urandom), 32'($urandom), 32'($urandom)};
      bus_b.q_sel = 3'($urandom);
    end
  endtask

  // Present one request and let the next rising edge accept it.
  task automatic drive(input int inst, input int unsigned qsel, input int unsigned qsv,
                       input int unsigned k[8], input string tag);
    check({tag, "_ready_in"}, 64'(get_ready_in(inst)), 64'd1);
    scramble(inst);
    if (inst == 0) begin
      bus_a.q_sel = 2'(qsel);
      bus_a.q_bus[qsel*8 +: 8] = 8'(qsv);
      for (int i = 0; i < 4; i++) bus_a.k_bus[i*8 +: 8] = 8'(k[i]);
      bus_a.valid_in = 1'b1;
    end else begin
      bus_b.q_sel = 3'(qsel);
      bus_b.q_bus[qsel*12 +: 12] = 12'(qsv);
      for (int i = 0; i < 8; i++) bus_b.k_bus[i*12 +: 12] = 12'(k[i]);
      bus_b.valid_in = 1'b1;
    end
    @(posedge clk);
    #1;
    bus_a.valid_in = 1'b0;
    bus_b.valid_in = 1'b0;
    scramble(inst);
  endtask

  task automatic wait_result(input int inst, input string tag);
    int cyc = 0;
    int exp_lat = (inst == 0) ? (2*4 + 4*9) : (2*8 + 8*11);
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (get_valid_out(inst) !== 1'b1 && cyc < 400);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  task automatic check_outputs(input int inst, input int unsigned sc[8],
                               input int unsigned win, input string tag);
    int n = (inst == 0) ? 4 : 8;
    check({tag, "_winner"}, get_winner(inst), 64'(win));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_score%0d", tag, i), get_score(inst, i), 64'(sc[i]));
  endtask

  task automatic release_result(input int inst, input string tag);
    if (inst == 0) bus_a.ready_out = 1'b1; else bus_b.ready_out = 1'b1;
    @(posedge clk);
    #1;
    bus_a.ready_out = 1'b0;
    bus_b.ready_out = 1'b0;
    check({tag, "_valid_out_clr"}, 64'(get_valid_out(inst)), 64'd0);
  endtask

  task automatic run_txn(input int inst, input int unsigned qsel, input int unsigned qsv,
                         input int unsigned k[8], input string tag);
    int unsigned sc[8];
    int unsigned win;
    if (inst == 0) ref_model(4, 8, 0, qsv, k, sc, win);
    else           ref_model(8, 10, 0, qsv, k, sc, win);
    drive(inst, qsel, qsv, k, tag);
    wait_result(inst, tag);
    check_outputs(inst, sc, win, tag);
    release_result(inst, tag);
  endtask

  initial begin
    int unsigned k[8];
    int unsigned sc[8];
    int unsigned win;

    bus_a.valid_in = 1'b0; bus_a.ready_out = 1'b0;
    bus_b.valid_in = 1'b0; bus_b.ready_out = 1'b0;
    scramble(0);
    scramble(1);

    // reset state
    #12;
    check("rst_valid_out", 64'(bus_a.valid_out), 64'd0);
    check("rst_busy", 64'(bus_a.busy), 64'd0);
    check("rst_winner", 64'(bus_a.winner), 64'd0);
    check("rst_scores", 64'(bus_a.score_bus), 64'd0);
    check("rst_b_scores", 64'(bus_b.score_bus), 64'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready_in", 64'(bus_a.ready_in), 64'd1);

    // uneven scores
    k = '{0, 0, 0, 4, 0, 0, 0, 0};
    run_txn(0, 0, 64, k, "uneven");

    // graded scores
    k = '{0, 4, 8, 12, 0, 0, 0, 0};
    run_txn(0, 2, 8, k, "graded");

    // ties, then zero query
    k = '{5, 5, 5, 5, 0, 0, 0, 0};
    run_txn(0, 1, 9, k, "ties");
    run_txn(0, 3, 0, k, "ties_q0");

    // backpressure with an ignored request while holding
    k = '{0, 4, 8, 12, 0, 0, 0, 0};
    ref_model(4, 8, 0, 8, k, sc, win);
    drive(0, 0, 8, k, "bp");
    wait_result(0, "bp");
    for (int c = 0; c < 20; c++) begin
      bus_a.valid_in = (c == 5);
      if (c == 5) begin bus_a.k_bus = 32'hFFFF_FFFF; bus_a.q_bus = 32'hFFFF_FFFF; end
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_valid_out_c%0d", c), 64'(bus_a.valid_out), 64'd1);
      check($sformatf("bp_hold_ready_in_c%0d", c), 64'(bus_a.ready_in), 64'd0);
    end
    bus_a.valid_in = 1'b0;
    check_outputs(0, sc, win, "bp_held");
    release_result(0, "bp");
    check("bp_idle_ready_in", 64'(bus_a.ready_in), 64'd1);
    check("bp_idle_busy", 64'(bus_a.busy), 64'd0);
    k = '{7, 3, 9, 1, 0, 0, 0, 0};
    run_txn(0, 1, 17, k, "bp_next");

    // reset in the middle of DIV
    k = '{0, 4, 8, 12, 0, 0, 0, 0};
    drive(0, 0, 8, k, "rst_mid");
    repeat (19) @(posedge clk);
    #1;
    check("rst_mid_busy_before", 64'(bus_a.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid_out", 64'(bus_a.valid_out), 64'd0);
    check("rst_mid_scores", 64'(bus_a.score_bus), 64'd0);
    check("rst_mid_winner", 64'(bus_a.winner), 64'd0);
    check("rst_mid_busy", 64'(bus_a.busy), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ready_in", 64'(bus_a.ready_in), 64'd1);
    run_txn(0, 2, 8, k, "after_rst");

    // random vectors, default parameters
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) k[i] = (t % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      run_txn(0, $urandom_range(0, 3), (t % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15),
              k, $sformatf("rand_a%0d", t));
    end

    // parameter sweep instance N=8 WIDTH=12 SCORE_W=10
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) k[i] = (t % 2 == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 31);
      run_txn(1, $urandom_range(0, 7), (t % 2 == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 15),
              k, $sformatf("rand_b%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/softmax_attention_seq.md
Name: softmax_attention_seq

Overview:
- Parametrised, resource-shared successor to the fixed 4-token softmax attention reference.
- Takes one selectable query and N keys per transaction, then computes the dot products on one shared multiplier.
- Applies max-subtracted (numerically stable) exp approximation, sums, and normalises with a serial divider.
- Outputs scores plus argmax winner under valid/ready handshakes; it is the softmax baseline for PST_core comparison at arbitrary N/WIDTH.

Parameters:
- N, 4, token count (>=2).
- WIDTH, 8, bit width of each query/key element.
- SCORE_W, 8, width of each normalised score.
- SHIFT, 0, right shift applied to (max_dot - dot_i) before the exp LUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  input transaction valid.
- ready_in  out  1  block can accept a transaction (high only in IDLE).
- q_sel  in  clog2(N)  index of the query element used for this transaction.
- q_bus  in  N*WIDTH  query elements; token i at [i*WIDTH +: WIDTH].
- k_bus  in  N*WIDTH  key elements; same packing as q_bus.
- valid_out  out  1  result valid, held until accepted.
- ready_out  in  1  downstream accepts the result.
- winner  out  clog2(N)  argmax token index.
- score_bus  out  N*SCORE_W  normalised scores; token i at [i*SCORE_W +: SCORE_W].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - valid_out=0, winner=0, score_bus=0, busy=0, ready_in=1 once rst_n is high.
  - All internal registers clear.
- IDLE: ready_in=1.
  - When valid_in&&ready_in at an edge, latch qv=q_bus[q_sel] and all of k_bus.
  - Clear idx, max_dot, winner_r and sum; go to DOT.
  - Input buses may change after acceptance.
- DOT (N cycles):
  - Each cycle, dot[idx]=qv*k[idx] (unsigned, 2*WIDTH bits).
  - If idx==0 or dot>max_dot, set max_dot=dot and winner_r=idx. Ties keep the lowest index.
  - After idx==N-1, go to EXP with idx=0.
- EXP (N cycles):
  - d = (max_dot - dot[idx]) >> SHIFT, saturated to 255 (8 bits).
  - e[idx] = 255 >> d[7:5], giving values 255, 127, 63, 31, 15, 7, 3, 1.
  - sum += e[idx]; SUM_W = 8 + clog2(N) + 1.
  - The max token always yields 255, so sum >= 255 and divide-by-zero is impossible.
- DIV (N*(SCORE_W+1) cycles):
  - Per token: 1 launch cycle, then SCORE_W restoring-divider iterations.
  - score_i = floor(e_i*(2^SCORE_W-1)/sum). The quotient always fits SCORE_W bits because e_i <= sum.
  - Go to OUT after the last token completes.
- OUT:
  - valid_out=1; winner and score_bus are stable and only change through reset.
  - On valid_out&&ready_out, clear valid_out and go to IDLE. The next accept is possible one cycle later.
- Latency:
  - valid_out rises exactly 2N + N*(SCORE_W+1) cycles after the accepting edge.
  - Defaults: 44 cycles.
- valid_in while busy: ignored and not queued (ready_in=0).
- ready_out stuck low: results hold indefinitely with no overwrite.
- Reset mid-operation: immediately aborts to IDLE with reset output values; there is no partial output.
- Outputs are registered; no combinational path from valid_in to valid_out.

Decomposition:
- Package softmax_seq_pkg holds:
  - state encoding (IDLE, DOT, EXP, DIV, OUT);
  - exp_neg LUT function;
  - SUM_W and index-width localparam formulas.
- One sub-module, seq_divider_restoring:
  - parameters NUM_W, DEN_W, Q_W;
  - ports start, num, den, done, quo;
  - done pulses after Q_W cycles.

Test Plan:
- Uneven scores: q_sel=0, q=64, k={0,0,0,4} -> dots {0,0,0,256}, e={1,1,1,255}, sum=258, scores={0,0,0,252}, winner=3, valid_out at cycle 44.
- Graded scores: q=8, k={0,4,8,12} -> e={31,63,127,255}, sum=476, scores={16,33,68,136}, winner=3.
- Ties: all k=5, q=9 -> scores {63,63,63,63}, winner=0; q=0 gives the same result.
- Backpressure: hold ready_out=0 for 20 cycles -> valid_out and outputs stable, ready_in=0, and a valid_in pulse meanwhile is ignored. Release -> IDLE, and the next transaction returns correct results.
- Reset mid-DIV: drop rst_n at cycle 20 -> valid_out=0, scores=0, winner=0, busy=0 asynchronously. A new transaction after release completes with correct values.
- Parameter sweep: N=8, WIDTH=12, SCORE_W=10, random vectors -> scores match a floor-arithmetic golden model exactly, and latency is 2N+N*(SCORE_W+1)=104.
